hamming_7_4_decoder_stream: RTL and testbench

HAMMING_7_4_DECODER_STREAM -- requirements
Module: hamming_7_4_decoder_stream

---
 rtl/hamming_pkg.sv | 36 +++
 rtl/hamming_7_4_syndrome.sv | 13 +
 rtl/hamming_7_4_decoder_stream.sv | 110 +++++++++++
 tb/tb_hamming_7_4_decoder_stream.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming(7,4) constants, parity equations and syndrome-to-bit map
package hamming_pkg;

    localparam int P = 3;
    localparam int N = 2**P - 1;
    localparam int K = 2**P - P - 1;

    // Parity bits {p2,p1,p0} for data {d3,d2,d1,d0}; shared with the encoder.
    function automatic logic [P-1:0] calc_parity(input logic [K-1:0] d);
        return {d[3] ^ d[2] ^ d[1],
                d[3] ^ d[2] ^ d[0],
                d[3] ^ d[1] ^ d[0]};
    endfunction

    function automatic logic [P-1:0] calc_syndrome(input logic [N-1:0] cw);
        return cw[P-1:0] ^ calc_parity(cw[N-1:P]);
    endfunction

    // One-hot mask of the codeword bit a nonzero syndrome points at.
    function automatic logic [N-1:0] syndrome_to_mask(input logic [P-1:0] syn);
        logic [N-1:0] mask;
        mask = '0;
        case (syn)
            3'b111:  mask = 7'b100_0000;
            3'b110:  mask = 7'b010_0000;
            3'b101:  mask = 7'b001_0000;
            3'b011:  mask = 7'b000_1000;
            3'b100:  mask = 7'b000_0100;
            3'b010:  mask = 7'b000_0010;
            3'b001:  mask = 7'b000_0001;
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/hamming_7_4_syndrome.sv
// rtl/hamming_7_4_syndrome.sv - combinational syndrome and single-bit correction of a codeword
module hamming_7_4_syndrome
    import hamming_pkg::*;
(
    input  logic [N-1:0] codeword,
    output logic [P-1:0] syndrome,
    output logic [N-1:0] corrected
);

    assign syndrome  = calc_syndrome(codeword);
    assign corrected = codeword ^ syndrome_to_mask(syndrome);

endmodule

// File: rtl/hamming_7_4_decoder_stream.sv
// rtl/hamming_7_4_decoder_stream.sv - two-stage Hamming(7,4) decoder stream; HAMMING_ERR_COUNT_EN adds word/error counters
module hamming_7_4_decoder_stream #(
    parameter int P = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2**P-2:0]      in_msg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2**P-P-2:0]    out_data,
    output logic                 out_corrected,
    output logic [P-1:0]         out_syndrome
`ifdef HAMMING_ERR_COUNT_EN
    ,
    input  logic                 clear_counts,
    output logic [15:0]          word_count,
    output logic [15:0]          err_count
`endif
);

    import hamming_pkg::*;

    if (P != 3) begin : g_bad_p
        $error("hamming_7_4_decoder_stream: only P=3 is supported");
    end

    logic           s1_valid;
    logic [N-1:0]   s1_msg;
    logic [P-1:0]   s1_syn;

    logic           s2_valid;
    logic [K-1:0]   s2_data;
    logic           s2_corr;
    logic [P-1:0]   s2_syn;

    logic           s2_ready;
    logic [N-1:0]   fixed_cw;
    logic [P-1:0]   fixed_syn;
    logic           unused_parity;

    // A stage can load when it is empty or its contents leave this cycle.
    assign s2_ready = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_msg   <= '0;
            s1_syn   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_msg <= in_msg;
                s1_syn <= calc_syndrome(in_msg);
            end
        end
    end

    hamming_7_4_syndrome u_syndrome (
        .codeword  (s1_msg),
        .syndrome  (fixed_syn),
        .corrected (fixed_cw)
    );

    // Corrected parity bits are not part of the delivered result.
    assign unused_parity = ^fixed_cw[P-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_corr  <= 1'b0;
            s2_syn   <= '0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= fixed_cw[N-1:P];
                s2_corr <= |s1_syn;
                s2_syn  <= fixed_syn;
            end
        end
    end

    assign out_valid     = s2_valid;
    assign out_data      = s2_data;
    assign out_corrected = s2_corr;
    assign out_syndrome  = s2_syn;

`ifdef HAMMING_ERR_COUNT_EN
    logic delivered;
    assign delivered = s2_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || clear_counts) begin
            word_count <= '0;
            err_count  <= '0;
        end else if (delivered) begin
            if (word_count != 16'hFFFF) begin
                word_count <= word_count + 16'd1;
            end
            if (s2_corr && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hamming_7_4_decoder_stream.sv
// tb/tb_hamming_7_4_decoder_stream.sv - directed self-checking bench for hamming_7_4_decoder_stream
module tb_hamming_7_4_decoder_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_msg;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_corrected;
    logic [2:0] out_syndrome;
`ifdef HAMMING_ERR_COUNT_EN
    logic        clear_counts;
    logic [15:0] word_count;
    logic [15:0] err_count;
`endif

    int checks   = 0;
    int failures = 0;
    int word_q[$];

    always #5 clk = ~clk;

    hamming_7_4_decoder_stream dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_msg        (in_msg),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_corrected (out_corrected),
        .out_syndrome  (out_syndrome)
`ifdef HAMMING_ERR_COUNT_EN
        ,
        .clear_counts  (clear_counts),
        .word_count    (word_count),
        .err_count     (err_count)
`endif
    );

    function automatic logic [2:0] parity_of(input logic [3:0] d);
        return {d[3] ^ d[2] ^ d[1], d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0]};
    endfunction

    function automatic logic [2:0] syn_of_bit(input int b);
        case (b)
            6:       return 3'b111;
            5:       return 3'b110;
            4:       return 3'b101;
            3:       return 3'b011;
            2:       return 3'b100;
            1:       return 3'b010;
            0:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Index i: data = i[6:3], flipped bit = i[2:0] (7 means no flip).
    function automatic logic [6:0] build(input int i);
        logic [3:0] d;
        logic [6:0] cw;
        int f;
        d  = 4'(i >> 3);
        f  = i & 7;
        cw = {d, parity_of(d)};
        if (f < 7) cw[f] = ~cw[f];
        return cw;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_one(input string tag, input logic [6:0] msg,
                            input logic [3:0] ed, input logic ec, input logic [2:0] es);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_msg   = msg;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_msg   = 7'h55;
        @(negedge clk);
        chk({tag, "_early"}, 16'(out_valid), 16'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_valid"}, 16'(out_valid), 16'd1);
        chk({tag, "_data"}, 16'(out_data), 16'(ed));
        chk({tag, "_corr"}, 16'(out_corrected), 16'(ec));
        chk({tag, "_syn"}, 16'(out_syndrome), 16'(es));
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_gone"}, 16'(out_valid), 16'd0);
    endtask

    task automatic run_words(input string tag);
        int sent;
        int rcv;
        int n;
        int idx;
        sent = 0;
        rcv  = 0;
        n    = word_q.size();
        @(posedge clk); #1;
        for (int cyc = 0; cyc < n + 6; cyc++) begin
            if (sent < n) begin
                in_valid = 1'b1;
                in_msg   = build(word_q[sent]);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid) begin
                if (rcv < n) begin
                    idx = word_q[rcv];
                    chk({tag, "_data"}, 16'(out_data), 16'(idx >> 3));
                    chk({tag, "_corr"}, 16'(out_corrected), 16'((idx & 7) != 7));
                    chk({tag, "_syn"}, 16'(out_syndrome), 16'(syn_of_bit(idx & 7)));
                end else begin
                    chk({tag, "_extra"}, 16'd1, 16'd0);
                end
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk({tag, "_count"}, 16'(rcv), 16'(n));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_msg    = '0;
        out_ready = 1'b1;
`ifdef HAMMING_ERR_COUNT_EN
        clear_counts = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_valid", 16'(out_valid), 16'd0);
        chk("rst_data", 16'(out_data), 16'd0);
        chk("rst_corr", 16'(out_corrected), 16'd0);
        chk("rst_syn", 16'(out_syndrome), 16'd0);
`ifdef HAMMING_ERR_COUNT_EN
        chk("rst_wcnt", word_count, 16'd0);
        chk("rst_ecnt", err_count, 16'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 16'(in_ready), 16'd1);

        send_one("clean",  7'b0011110, 4'b0011, 1'b0, 3'b000);
        send_one("flip6",  7'b1011110, 4'b0011, 1'b1, 3'b111);
        send_one("flip0",  7'b0011111, 4'b0011, 1'b1, 3'b001);
        send_one("flip5",  7'b0111110, 4'b0011, 1'b1, 3'b110);
        send_one("flip2",  7'b0011010, 4'b0011, 1'b1, 3'b100);
        send_one("double", 7'b0011101, 4'b0010, 1'b1, 3'b011);

        // Backpressure: two words fill the pipe, the third waits.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_msg    = 7'b1111111;
        @(negedge clk);
        chk("bp_rdy0", 16'(in_ready), 16'd1);
        @(posedge clk); #1;
        in_msg = 7'b1010010;
        @(negedge clk);
        chk("bp_rdy1", 16'(in_ready), 16'd1);
        @(posedge clk); #1;
        in_msg = 7'b1001100;
        @(negedge clk);
        chk("bp_rdy2", 16'(in_ready), 16'd0);
        chk("bp_valid", 16'(out_valid), 16'd1);
        chk("bp_data0", 16'(out_data), 16'hF);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_hold_rdy", 16'(in_ready), 16'd0);
        chk("bp_hold_valid", 16'(out_valid), 16'd1);
        chk("bp_hold_data", 16'(out_data), 16'hF);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_rdy", 16'(in_ready), 16'd1);
        chk("bp_out0", 16'(out_data), 16'hF);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_out1_valid", 16'(out_valid), 16'd1);
        chk("bp_out1", 16'(out_data), 16'hA);
        chk("bp_out1_corr", 16'(out_corrected), 16'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_out2_valid", 16'(out_valid), 16'd1);
        chk("bp_out2", 16'(out_data), 16'h9);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_drained", 16'(out_valid), 16'd0);

        // Reset with two words in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_msg    = 7'b1111111;
        @(posedge clk); #1;
        in_msg = 7'b1010010;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        chk("mid_inflight", 16'(out_valid), 16'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_valid", 16'(out_valid), 16'd0);
        chk("mid_data", 16'(out_data), 16'd0);
        chk("mid_ready", 16'(in_ready), 16'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("mid_stale", 16'(out_valid), 16'd0);
        end

        word_q.delete();
        for (int i = 0; i < 128; i++) word_q.push_back(i);
        run_words("exh");

`ifdef HAMMING_ERR_COUNT_EN
        @(posedge clk); #1;
        clear_counts = 1'b1;
        @(posedge clk); #1;
        clear_counts = 1'b0;
        @(negedge clk);
        chk("cnt_clr_w", word_count, 16'd0);
        chk("cnt_clr_e", err_count, 16'd0);
        word_q.delete();
        word_q = '{7, 15, 23, 31, 39, 40, 51, 62};
        run_words("cnt");
        @(negedge clk);
        chk("cnt_words", word_count, 16'd8);
        chk("cnt_errs", err_count, 16'd3);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_msg    = build(66);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("cnt_pending", 16'(out_valid), 16'd1);
        chk("cnt_pending_w", word_count, 16'd8);
        clear_counts = 1'b1;
        out_ready    = 1'b1;
        @(posedge clk); #1;
        clear_counts = 1'b0;
        @(negedge clk);
        chk("cnt_prio_w", word_count, 16'd0);
        chk("cnt_prio_e", err_count, 16'd0);
        chk("cnt_prio_hs", 16'(out_valid), 16'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
